// File: rtl/mem_wb_skid_stage_if.sv
// mem_wb_skid_stage_if: MEM-to-WB handshake and payload bus for the skid stage
interface mem_wb_skid_stage_if #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_wregen;
  logic [DATA_W-1:0] in_dout;
  logic [REG_AW-1:0] in_wreg;
  logic              out_valid;
  logic              out_ready;
  logic              out_wregen;
  logic [DATA_W-1:0] out_dout;
  logic [REG_AW-1:0] out_wreg;
  logic [1:0]        occ;
  modport slave (
    input  flush, in_valid, in_wregen, in_dout, in_wreg, out_ready,
    output in_ready, out_valid, out_wregen, out_dout, out_wreg, occ
  );
  modport master (
    output flush, in_valid, in_wregen, in_dout, in_wreg, out_ready,
    input  in_ready, out_valid, out_wregen, out_dout, out_wreg, occ
  );
endinterface

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: 2-entry MEM/WB skid buffer with registered in_ready and flush
module mem_wb_skid_stage #(
  parameter int DATA_W        = 64,
  parameter int REG_AW        = 5,
  parameter int SUPPRESS_ZERO = 1
) (
  input logic               clk,
  input logic               reset,
  mem_wb_skid_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic              wregen;
    logic [DATA_W-1:0] dout;
    logic [REG_AW-1:0] wreg;
  } entry_t;
  state_t     state;
  entry_t     head, skid, in_e;
  logic       rdy, push, pop;
  logic [1:0] occ_q;
  assign push = bus.in_valid & rdy;
  assign pop  = (state != EMPTY) & bus.out_ready;
  // Writes to register 0 are architecturally dead, so their enable is dropped here.
  assign in_e = '{wregen: bus.in_wregen & ~(SUPPRESS_ZERO != 0 && bus.in_wreg == '0),
                  dout:   bus.in_dout,
                  wreg:   bus.in_wreg};
  assign bus.in_ready   = rdy;
  assign bus.out_valid  = state != EMPTY;
  assign bus.out_wregen = head.wregen;
  assign bus.out_dout   = head.dout;
  assign bus.out_wreg   = head.wreg;
  assign bus.occ        = occ_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
      rdy   <= 1'b0;
      occ_q <= 2'd0;
    end else if (bus.flush) begin
      state <= EMPTY;
      rdy   <= 1'b1;
      occ_q <= 2'd0;
    end else begin
      rdy <= 1'b1;
      case (state)
        EMPTY: if (push) begin
          head  <= in_e;
          state <= ONE;
          occ_q <= 2'd1;
        end
        ONE: if (push && !pop) begin
          skid  <= in_e;
          state <= TWO;
          rdy   <= 1'b0;
          occ_q <= 2'd2;
        end else if (pop && !push) begin
          state <= EMPTY;
          occ_q <= 2'd0;
        end else if (push) begin
          head <= in_e;
        end
        TWO: if (pop) begin
          head  <= skid;
          state <= ONE;
          occ_q <= 2'd1;
        end else begin
          rdy <= 1'b0;
        end
        default: begin
          state <= EMPTY;
          occ_q <= 2'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// tb_mem_wb_skid_stage: directed and random checks of the skid stage against a queue model
module tb_mem_wb_skid_stage;
  typedef struct {
    logic        w;
    logic [63:0] d;
    logic [4:0]  r;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  logic ready_m = 1'b0;
  always #5 clk = ~clk;
  mem_wb_skid_stage_if #(.DATA_W(64), .REG_AW(5)) b0 ();
  mem_wb_skid_stage_if #(.DATA_W(64), .REG_AW(5)) b1 ();
  assign b1.flush     = b0.flush;
  assign b1.in_valid  = b0.in_valid;
  assign b1.in_wregen = b0.in_wregen;
  assign b1.in_dout   = b0.in_dout;
  assign b1.in_wreg   = b0.in_wreg;
  assign b1.out_ready = b0.out_ready;
  mem_wb_skid_stage #(.DATA_W(64), .REG_AW(5), .SUPPRESS_ZERO(1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  mem_wb_skid_stage #(.DATA_W(64), .REG_AW(5), .SUPPRESS_ZERO(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_model(input string tag);
    chk({tag, ".occ"}, 64'(b0.occ), 64'(q.size()));
    chk({tag, ".valid"}, 64'(b0.out_valid), 64'(q.size() > 0));
    chk({tag, ".ready"}, 64'(b0.in_ready), 64'(ready_m));
    chk({tag, ".occ1"}, 64'(b1.occ), 64'(q.size()));
    if (q.size() > 0) begin
      chk({tag, ".wregen"}, 64'(b0.out_wregen), 64'(q[0].w && q[0].r != 5'd0));
      chk({tag, ".wregen_nosup"}, 64'(b1.out_wregen), 64'(q[0].w));
      chk({tag, ".dout"}, b0.out_dout, q[0].d);
      chk({tag, ".wreg"}, 64'(b0.out_wreg), 64'(q[0].r));
      chk({tag, ".dout1"}, b1.out_dout, q[0].d);
    end
  endtask
  task automatic step(input string tag);
    bit   push, pop;
    ent_t e;
    push = b0.in_valid && ready_m;
    pop  = q.size() > 0 && b0.out_ready;
    e    = '{b0.in_wregen, b0.in_dout, b0.in_wreg};
    @(posedge clk);
    if (reset) begin
      if (b0.flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
      ready_m = q.size() < 2;
    end
    #1;
    check_model(tag);
  endtask
  task automatic drive(input logic v, input logic w, input logic [63:0] d, input logic [4:0] r);
    b0.in_valid  = v;
    b0.in_wregen = w;
    b0.in_dout   = d;
    b0.in_wreg   = r;
  endtask
  initial begin
    b0.flush = 1'b0;
    b0.out_ready = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 5'd0);
    #1;
    chk("rst.occ", 64'(b0.occ), 64'd0);
    chk("rst.valid", 64'(b0.out_valid), 64'd0);
    chk("rst.ready", 64'(b0.in_ready), 64'd0);
    chk("rst.wregen", 64'(b0.out_wregen), 64'd0);
    chk("rst.dout", b0.out_dout, 64'd0);
    chk("rst.wreg", 64'(b0.out_wreg), 64'd0);
    step("rst_hold");
    reset = 1'b1;
    step("rst_release");
    chk("rst_release.ready_rise", 64'(b0.in_ready), 64'd1);
    // single pass
    b0.out_ready = 1'b1;
    drive(1'b1, 1'b1, 64'h1122334455667788, 5'd7);
    step("single");
    chk("single.dout_const", b0.out_dout, 64'h1122334455667788);
    drive(1'b0, 1'b0, 64'd0, 5'd0);
    step("single_drain");
    chk("single_drain.occ0", 64'(b0.occ), 64'd0);
    // backpressure
    b0.out_ready = 1'b0;
    drive(1'b1, 1'b1, 64'hAAAA, 5'd3);
    step("bp_a");
    drive(1'b1, 1'b0, 64'hBBBB, 5'd4);
    step("bp_b");
    chk("bp.occ2", 64'(b0.occ), 64'd2);
    chk("bp.ready0", 64'(b0.in_ready), 64'd0);
    chk("bp.head_a", b0.out_dout, 64'hAAAA);
    drive(1'b0, 1'b0, 64'd0, 5'd0);
    step("bp_hold");
    b0.out_ready = 1'b1;
    step("bp_pop_a");
    chk("bp.head_b", b0.out_dout, 64'hBBBB);
    step("bp_pop_b");
    chk("bp.ready_back", 64'(b0.in_ready), 64'd1);
    // streaming
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 64'h5000 + 64'(i), 5'(i + 1));
      step("stream");
      chk("stream.dout_const", b0.out_dout, 64'h5000 + 64'(i));
    end
    drive(1'b0, 1'b0, 64'd0, 5'd0);
    step("stream_drain");
    // zero register
    drive(1'b1, 1'b1, 64'hFF, 5'd0);
    step("zero");
    chk("zero.wregen_sup", 64'(b0.out_wregen), 64'd0);
    chk("zero.wregen_nosup", 64'(b1.out_wregen), 64'd1);
    chk("zero.dout", b0.out_dout, 64'hFF);
    drive(1'b0, 1'b0, 64'd0, 5'd0);
    step("zero_drain");
    // flush in TWO with simultaneous push
    b0.out_ready = 1'b0;
    drive(1'b1, 1'b1, 64'hA1, 5'd1);
    step("fl_a");
    drive(1'b1, 1'b1, 64'hB2, 5'd2);
    step("fl_b");
    b0.flush = 1'b1;
    b0.out_ready = 1'b1;
    drive(1'b1, 1'b1, 64'hC3, 5'd3);
    step("flush");
    chk("flush.ready1", 64'(b0.in_ready), 64'd1);
    chk("flush.valid0", 64'(b0.out_valid), 64'd0);
    b0.flush = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 5'd0);
    step("flush_after");
    step("flush_after2");
    // asynchronous reset in TWO
    b0.out_ready = 1'b0;
    drive(1'b1, 1'b1, 64'hD4, 5'd5);
    step("ar_a");
    drive(1'b1, 1'b1, 64'hE5, 5'd6);
    step("ar_b");
    drive(1'b0, 1'b0, 64'd0, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    q.delete();
    ready_m = 1'b0;
    chk("ar.occ", 64'(b0.occ), 64'd0);
    chk("ar.valid", 64'(b0.out_valid), 64'd0);
    chk("ar.ready", 64'(b0.in_ready), 64'd0);
    chk("ar.wregen", 64'(b0.out_wregen), 64'd0);
    chk("ar.dout", b0.out_dout, 64'd0);
    chk("ar.wreg", 64'(b0.out_wreg), 64'd0);
    step("ar_hold");
    reset = 1'b1;
    step("ar_release");
    chk("ar_release.ready", 64'(b0.in_ready), 64'd1);
    drive(1'b1, 1'b1, 64'hF6, 5'd9);
    step("ar_push");
    chk("ar_push.dout", b0.out_dout, 64'hF6);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      b0.flush = ($urandom_range(0, 15) == 0);
      b0.out_ready = $urandom_range(0, 2) != 0;
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
      step("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
